// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - two-port arbiter and access screen in front of the single-port data memory
module dmem_arb #(
    parameter int AW         = 11,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          p0_valid,
    output logic          p0_ready,
    input  logic          p0_we,
    input  logic [1:0]    p0_size,
    input  logic [31:0]   p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_rsp_valid,
    output logic          p0_rsp_err,
    output logic [31:0]   p0_rsp_rdata,
    input  logic          p1_valid,
    output logic          p1_ready,
    input  logic          p1_we,
    input  logic [1:0]    p1_size,
    input  logic [31:0]   p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_rsp_valid,
    output logic          p1_rsp_err,
    output logic [31:0]   p1_rsp_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]  starve_cnt;
    logic        grant0;
    logic        grant1;
    logic        granted;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;
    logic        legal;
    logic        rsp0_q;
    logic        rsp1_q;
    logic        rsp_err_q;
    logic        rsp_load_q;
    logic [31:0] rsp_word;

    // Grant selection: fixed priority to the CPU, overridden once the loader has starved long enough
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && !stall) begin
            if (p0_valid && p1_valid) begin
                if (starve_cnt == STARVE_LIM) begin
                    grant1 = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else if (p0_valid) begin
                grant0 = 1'b1;
            end else if (p1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    // Steer the granted request and screen it for size, alignment and range errors
    always_comb begin
        sel_we    = grant1 ? p1_we    : p0_we;
        sel_size  = grant1 ? p1_size  : p0_size;
        sel_addr  = grant1 ? p1_addr  : p0_addr;
        sel_wdata = grant1 ? p1_wdata : p0_wdata;
        sel_err   = (sel_size == 2'b11)
                  || (sel_size == 2'b01 && sel_addr[0] != 1'b0)
                  || (sel_size == 2'b10 && sel_addr[1:0] != 2'b00)
                  || (sel_addr[31:AW] != '0);
        granted   = grant0 || grant1;
        legal     = granted && !sel_err;
    end

    // Memory command: driven only for a legal grant, otherwise all zero
    always_comb begin
        mem_en    = legal;
        mem_we    = legal && sel_we;
        mem_size  = legal ? sel_size : 2'b00;
        mem_addr  = legal ? sel_addr[AW-1:0] : '0;
        mem_wdata = legal ? sel_wdata : 32'h0;
        p0_ready  = grant0;
        p1_ready  = grant1;
    end

    // In-flight response bookkeeping: which port, error flag, and whether read data is due
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
        end else begin
            rsp0_q     <= grant0;
            rsp1_q     <= grant1;
            rsp_err_q  <= granted && sel_err;
            rsp_load_q <= legal && !sel_we;
        end
    end

    // Starvation counter: counts CPU wins while the loader is waiting, saturating at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (!p1_valid || grant1) begin
            starve_cnt <= 4'd0;
        end else if (grant0 && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Response outputs; held at zero while reset is asserted so an in-flight response is dropped
    always_comb begin
        rsp_word     = rsp_load_q ? mem_rdata : 32'h0;
        p0_rsp_valid = rsp0_q && !rst;
        p1_rsp_valid = rsp1_q && !rst;
        p0_rsp_err   = p0_rsp_valid && rsp_err_q;
        p1_rsp_err   = p1_rsp_valid && rsp_err_q;
        p0_rsp_rdata = p0_rsp_valid ? rsp_word : 32'h0;
        p1_rsp_rdata = p1_rsp_valid ? rsp_word : 32'h0;
    end

endmodule
